// File: rtl/ntt_core_ram_ctrl_if.sv
// ntt_core_ram_ctrl_if: stream and ping-pong RAM port bundle for ntt_core_ram_ctrl
interface ntt_core_ram_ctrl_if #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int DATA_WIDTH = 60
);
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic ram_write_select;
  logic ram_write_enable;
  logic [LOG_CORE_COUNT-1:0] ram_write_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic ram_read_select;
  logic [LOG_CORE_COUNT-1:0] ram_read_address;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic [1:0] bank_full;
  modport slave (
    input in_valid, in_data, out_ready, ram_data_out,
    output in_ready, out_valid, out_data, ram_write_select, ram_write_enable,
    output ram_write_address, ram_data_in, ram_read_select, ram_read_address, bank_full
  );
  modport master (
    output in_valid, in_data, out_ready, ram_data_out,
    input in_ready, out_valid, out_data, ram_write_select, ram_write_enable,
    input ram_write_address, ram_data_in, ram_read_select, ram_read_address, bank_full
  );
endinterface

// File: rtl/ntt_core_ram_ctrl.sv
// ntt_core_ram_ctrl: ping-pong fill/drain controller for ntt_core_ram; NTT_BITREV_READ_EN selects bit-reversed read order
module ntt_core_ram_ctrl #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int DATA_WIDTH = 60
) (
  input logic clk,
  input logic rst,
  ntt_core_ram_ctrl_if.slave bus
);
  localparam int N = 1 << LOG_CORE_COUNT;
  logic wbank_q, wbank_d, rbank_q, rbank_d, inflight_q;
  logic [LOG_CORE_COUNT-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, raddr;
  logic [1:0] full_q, full_d, cnt_q, cnt_d, occ;
  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic accept, wlast, rd, rlast, push, pop;
  // Handshakes, bank swaps and the 2-entry return FIFO; occupancy counts the pop of this cycle so a steady drain issues every cycle
  always_comb begin
    accept = bus.in_valid && !full_q[wbank_q];
    wlast = accept && wcnt_q == LOG_CORE_COUNT'(N - 1);
    push = inflight_q;
    pop = cnt_q != 2'd0 && bus.out_ready;
    occ = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    rd = full_q[rbank_q] && occ < 2'd2;
    rlast = rd && rcnt_q == LOG_CORE_COUNT'(N - 1);
    wcnt_d = wcnt_q + LOG_CORE_COUNT'(accept);
    rcnt_d = rcnt_q + LOG_CORE_COUNT'(rd);
    full_d = (full_q | (wlast ? 2'b01 << wbank_q : 2'b00)) & ~(rlast ? 2'b01 << rbank_q : 2'b00);
    wbank_d = wbank_q ^ ((wlast || full_q[wbank_q]) && (!full_q[~wbank_q] || rlast));
    rbank_d = (rlast || (wlast && !full_q[rbank_q])) ? wbank_q : rbank_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = (pop && cnt_q == 2'd2) ? tail_q : (push && (pop || cnt_q == 2'd0)) ? bus.ram_data_out : head_q;
    tail_d = (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) ? bus.ram_data_out : tail_q;
    raddr = rcnt_q;
`ifdef NTT_BITREV_READ_EN
    for (int i = 0; i < LOG_CORE_COUNT; i++) raddr[i] = rcnt_q[LOG_CORE_COUNT-1-i];
`endif
  end
  // Port drive: write side passes the accepted word straight to the RAM
  always_comb begin
    bus.in_ready = !full_q[wbank_q];
    bus.ram_write_enable = accept;
    bus.ram_write_address = wcnt_q;
    bus.ram_data_in = bus.in_data;
    bus.ram_write_select = wbank_q;
    bus.ram_read_select = rbank_q;
    bus.ram_read_address = raddr;
    bus.out_valid = cnt_q != 2'd0;
    bus.out_data = head_q;
    bus.bank_full = full_q;
  end
  // Controller state; reset leaves bank contents untouched and drops queued data
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b1;
      wcnt_q <= '0;
      rcnt_q <= '0;
      full_q <= 2'b00;
      inflight_q <= 1'b0;
      cnt_q <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      full_q <= full_d;
      inflight_q <= rd;
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: tb/tb_ntt_core_ram_ctrl.sv
// tb_ntt_core_ram_ctrl: directed scoreboard bench with a behavioural two-bank RAM
module tb_ntt_core_ram_ctrl;
  localparam int L = 5;
  localparam int N = 32;
  localparam int DW = 60;
  logic clk, rst;
  ntt_core_ram_ctrl_if #(.LOG_CORE_COUNT(L), .DATA_WIDTH(DW)) bus ();
  ntt_core_ram_ctrl #(.LOG_CORE_COUNT(L), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [DW-1:0] mem [2][N];
  logic [DW-1:0] q [$];
  logic [DW-1:0] bbuf [N];
  logic [DW-1:0] hold_data;
  logic hold, acc, wb;
  int checks = 0, errors = 0, wexp = 0, pops = 0, stalls = 0, cyc = 0, first_pop = -1, last_pop = -1;
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_write_enable) mem[bus.ram_write_select][bus.ram_write_address] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_read_select][bus.ram_read_address];
  end
  function automatic int br(input int i);
    int r = i;
`ifdef NTT_BITREV_READ_EN
    r = 0;
    for (int b = 0; b < L; b++) if (i[b]) r |= 1 << (L - 1 - b);
`endif
    return r;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      wexp = 0;
      wb = 1'b0;
      q.delete();
      hold = 1'b0;
    end else begin
      acc = bus.in_valid && bus.in_ready;
      check("wr_en", 64'(bus.ram_write_enable), 64'(acc));
      if (acc) begin
        check("wr_addr", 64'(bus.ram_write_address), 64'(wexp));
        check("wr_sel", 64'(bus.ram_write_select), 64'(wb));
        check("wr_data", 64'(bus.ram_data_in), 64'(bus.in_data));
        bbuf[wexp] = bus.in_data;
        if (wexp == N - 1) begin
          for (int i = 0; i < N; i++) q.push_back(bbuf[br(i)]);
          wb = ~wb;
        end
        wexp = (wexp + 1) % N;
      end
      if (hold && bus.out_valid) check("hold_stable", 64'(bus.out_data), 64'(hold_data));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("extra_out", 64'(q.size()), 64'd1);
        else check("out_data", 64'(bus.out_data), 64'(q.pop_front()));
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      hold = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_full", 64'(bus.bank_full), 64'd0);
    check("rst_wsel", 64'(bus.ram_write_select), 64'd0);
    check("rst_rsel", 64'(bus.ram_read_select), 64'd1);
    check("rst_wen", 64'(bus.ram_write_enable), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
      n++;
      if (n > 300) begin
        check("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input bit tog);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      if (tog) bus.out_ready = ~bus.out_ready;
      n++;
    end
    bus.out_ready = 1'b1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < N; i++) send(DW'(100 + i));
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_full", 64'(bus.bank_full), 64'b01);
    check("t1_lat0", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("t1_lat1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("t1_lat2", 64'(bus.out_valid), 64'd1);
    check("t1_first", 64'(bus.out_data), 64'(100 + br(0)));
    drain(1'b0);
    @(negedge clk);
    check("t1_full_clear", 64'(bus.bank_full), 64'b00);
    do_reset();
    stalls = 0;
    first_pop = -1;
    for (int i = 0; i < 3 * N; i++) send(DW'(1000 + i));
    bus.in_valid = 1'b0;
    drain(1'b0);
    check("t2_stalls", 64'(stalls), 64'd0);
    check("t2_no_gaps", 64'(last_pop - first_pop), 64'(3 * N - 1));
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) send(DW'(200 + i));
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_full", 64'(bus.bank_full), 64'b11);
      check("t3_in_ready", 64'(bus.in_ready), 64'd0);
      check("t3_head", 64'(bus.out_data), 64'(200 + br(0)));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain(1'b0);
    @(negedge clk);
    check("t3_in_ready_back", 64'(bus.in_ready), 64'd1);
    check("t3_full_clear", 64'(bus.bank_full), 64'b00);
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < N; i++) send(DW'(300 + i));
    bus.in_valid = 1'b0;
    drain(1'b1);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < N; i++) send(DW'(400 + i));
    bus.in_valid = 1'b0;
    pops = 0;
    for (int n = 0; n < 200 && pops < 10; n++) begin
      @(posedge clk);
      #1;
    end
    check("t5_pops", 64'(pops), 64'd10);
    do_reset();
    for (int i = 0; i < N; i++) send(DW'(500 + i));
    bus.in_valid = 1'b0;
    drain(1'b0);
    do_reset();
    for (int i = 0; i < N; i++) send(DW'(i));
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t6_first", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    check("t6_second", 64'(bus.out_data), 64'(br(1)));
    drain(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
